// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if: block handshake bundle for the sequential InvSubBytes stage
//   in/in_valid/in_ready    : 128-bit AES state offered by upstream, ready/valid
//   out/out_valid/out_ready : 128-bit InvSubBytes result presented downstream
interface inv_sub_bytes_seq_if;
    logic [127:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out;
    logic         out_valid;
    logic         out_ready;
    modport slave  (input in, in_valid, out_ready, output in_ready, out, out_valid);
    modport master (output in, in_valid, out_ready, input in_ready, out, out_valid);
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes, one 32-bit word per cycle through four S-box lookups
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of inv_sub_bytes_seq_if (byte 0 in bits [127:120])
module inv_sub_bytes_seq (
    input logic               clk,
    input logic               rst_n,
    inv_sub_bytes_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_cnt;
    logic [127:0] r_work;
    logic [31:0]  w_word;
    logic [31:0]  w_sub;
    logic [6:0]   w_msb;

    // {~cnt, 5'h1f} maps cnt 0..3 to the top bit of word 0..3 (127, 95, 63, 31)
    assign w_msb  = {~r_cnt, 5'h1f};
    assign w_word = r_work[w_msb -: 32];

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_lut
            assign w_sub[8*b +: 8] = INV_SBOX[w_word[8*b +: 8]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? BUSY : IDLE;
            BUSY:    w_next = (r_cnt == 2'd3) ? DONE : BUSY;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_work <= bus.in;
            r_cnt  <= '0;
        end else if (r_state == BUSY) begin
            r_work[w_msb -: 32] <= w_sub;
            r_cnt               <= r_cnt + 2'd1;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out       = r_work;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed self-checking bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    inv_sub_bytes_seq_if bus();

    inv_sub_bytes_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [127:0] V_FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V_FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_ZERO_IN  = {16{8'h00}};
    localparam logic [127:0] V_ZERO_OUT = {16{8'h52}};
    localparam logic [127:0] V_63_IN    = {16{8'h63}};
    localparam logic [127:0] V_63_OUT   = {16{8'h00}};
    localparam logic [127:0] V_01FF_IN  = {8{16'h01ff}};
    localparam logic [127:0] V_01FF_OUT = {8{16'h097d}};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Offer a block from IDLE and return the number of edges until out_valid rises.
    task automatic start_block(input logic [127:0] data, output int lat);
        @(negedge clk);
        check("idle_in_ready", {127'd0, bus.in_ready}, 128'd1);
        bus.in       = data;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            if (n == 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_block;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handoff_in_ready", {127'd0, bus.in_ready}, 128'd1);
        check("handoff_out_valid", {127'd0, bus.out_valid}, 128'd0);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] data, input logic [127:0] req);
        int lat;
        start_block(data, lat);
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_out"}, bus.out, req);
        finish_block();
    endtask

    initial begin
        logic [127:0] vin  [4];
        logic [127:0] vout [4];
        int lat;
        int acc;
        int res;
        int last_acc;
        vin  = '{V_FIPS_IN,  V_ZERO_IN,  V_63_IN,  V_01FF_IN};
        vout = '{V_FIPS_OUT, V_ZERO_OUT, V_63_OUT, V_01FF_OUT};
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out", bus.out, 128'd0);
        check("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);

        run_block("fips", V_FIPS_IN, V_FIPS_OUT);
        run_block("zero", V_ZERO_IN, V_ZERO_OUT);
        run_block("x63", V_63_IN, V_63_OUT);
        run_block("x01ff", V_01FF_IN, V_01FF_OUT);

        // out_ready held low for 10 cycles with noise on the input side
        start_block(V_FIPS_IN, lat);
        check("hold_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in       = {$urandom, $urandom, $urandom, $urandom};
            bus.in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check("hold_out", bus.out, V_FIPS_OUT);
            check("hold_out_valid", {127'd0, bus.out_valid}, 128'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_block();

        // reset pulse after two words have been processed
        @(negedge clk);
        bus.in       = V_63_IN;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", bus.out, 128'd0);
        check("abort_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("abort_in_ready", {127'd0, bus.in_ready}, 128'd1);
        #1;
        rst_n = 1'b1;
        run_block("post_reset", V_01FF_IN, V_01FF_OUT);

        // back-to-back with in_valid and out_ready held high
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        acc = 0;
        res = 0;
        last_acc = -1;
        for (int c = 0; c < 60 && res < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.out_valid) begin
                if (res < 4) check("b2b_out", bus.out, vout[res]);
                res++;
            end
            if (bus.in_ready) begin
                if (acc > 0) check("b2b_period", 128'(c - last_acc), 128'd6);
                last_acc = c;
                bus.in = (acc < 4) ? vin[acc] : '0;
                acc++;
            end
        end
        check("b2b_results", 128'(res), 128'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (8) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
